// File: rtl/flit_injector.sv
// Source-side network interface: queues packet descriptors and serialises each
// packet into head/body/tail flits for router local port 0, one flit per step.
module flit_injector #(
   parameter int unsigned FLIT_W     = 22,
   parameter int unsigned NUM_VC     = 4,
   parameter int unsigned LEN_W      = 6,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              desc_valid,
   output logic              desc_ready,
   input  logic [13:0]       desc_dst,
   input  logic [LEN_W-1:0]  desc_len,
   input  logic [3:0]        desc_vc,
   input  logic              step,
   input  logic [NUM_VC-1:0] can_inject,
   output logic [FLIT_W-1:0] flit_out,
   output logic              idle,
   output logic [CNT_W-1:0]  pkt_count,
   output logic [CNT_W-1:0]  flit_count,
   output logic [CNT_W-1:0]  err_count
);

   localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned VcIdxW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
   localparam int unsigned DescW  = 14 + LEN_W + 4;

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   // Descriptor FIFO
   logic [DescW-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]    count_q, count_d;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   logic [DescW-1:0] head_desc;
   logic [13:0]      head_dst;
   logic [LEN_W-1:0] head_len;
   logic [3:0]       head_vc;

   // Packet state
   state_e            state_q, state_d;
   logic [13:0]       dst_q, dst_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [3:0]        vc_q, vc_d;
   logic              first_q, first_d;
   logic [NUM_VC-1:0] sent_q, sent_d;
   logic [NUM_VC-1:0] sent_set;
   logic [FLIT_W-1:0] flit_q, flit_d;
   logic [CNT_W-1:0]  pkt_q, pkt_d;
   logic [CNT_W-1:0]  flits_q, flits_d;
   logic [CNT_W-1:0]  err_q, err_d;

   logic [VcIdxW-1:0] vc_idx;
   logic              eligible;
   logic              is_tail;

   assign fifo_empty = (count_q == '0);
   assign desc_ready = (count_q != (PtrW + 1)'(FIFO_DEPTH));
   assign push       = desc_valid && desc_ready;

   assign head_desc = mem_q[rd_ptr_q];
   assign head_dst  = head_desc[DescW-1 -: 14];
   assign head_len  = head_desc[4 +: LEN_W];
   assign head_vc   = head_desc[3:0];

   assign vc_idx   = vc_q[VcIdxW-1:0];
   assign eligible = can_inject[vc_idx] && !sent_q[vc_idx];
   assign is_tail  = (rem_q == LEN_W'(1));

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {desc_dst, desc_len, desc_vc};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + (PtrW + 1)'(1);
         2'b01:   count_d = count_q - (PtrW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      dst_d    = dst_q;
      rem_d    = rem_q;
      vc_d     = vc_q;
      first_d  = first_q;
      flit_d   = flit_q;
      pkt_d    = pkt_q;
      flits_d  = flits_q;
      err_d    = err_q;
      sent_set = '0;
      pop      = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A step landing on the pop clock still produces an empty flit.
            if (step) begin
               flit_d = '0;
            end
            if (!fifo_empty) begin
               pop = 1'b1;
               if (head_len == '0 || 32'(head_vc) >= NUM_VC) begin
                  err_d = err_q + CNT_W'(1);
               end else begin
                  dst_d   = head_dst;
                  rem_d   = head_len;
                  vc_d    = head_vc;
                  first_d = 1'b1;
                  state_d = StSend;
               end
            end
         end
         StSend: begin
            if (step) begin
               if (eligible) begin
                  flit_d           = FLIT_W'({1'b1, vc_q, 1'b0, first_q, is_tail, dst_q});
                  sent_set[vc_idx] = 1'b1;
                  flits_d          = flits_q + CNT_W'(1);
                  first_d          = 1'b0;
                  rem_d            = rem_q - LEN_W'(1);
                  if (is_tail) begin
                     pkt_d   = pkt_q + CNT_W'(1);
                     state_d = StIdle;
                  end
               end else begin
                  flit_d = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Set wins over the clear that comes from the router absorbing the flit.
   assign sent_d = sent_set | (sent_q & can_inject);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= StIdle;
         dst_q    <= '0;
         rem_q    <= '0;
         vc_q     <= '0;
         first_q  <= 1'b0;
         sent_q   <= '0;
         flit_q   <= '0;
         pkt_q    <= '0;
         flits_q  <= '0;
         err_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         dst_q    <= dst_d;
         rem_q    <= rem_d;
         vc_q     <= vc_d;
         first_q  <= first_d;
         sent_q   <= sent_d;
         flit_q   <= flit_d;
         pkt_q    <= pkt_d;
         flits_q  <= flits_d;
         err_q    <= err_d;
      end
   end

   assign flit_out   = flit_q;
   assign pkt_count  = pkt_q;
   assign flit_count = flits_q;
   assign err_count  = err_q;
   assign idle       = fifo_empty && (state_q == StIdle) && (sent_q == '0);

endmodule

// File: tb/tb_flit_injector.sv
// Directed self-checking bench for flit_injector: reset, packet serialisation,
// VC gating, descriptor drops, FIFO back-pressure and mid-packet reset.
module tb_flit_injector;

   logic        clk;
   logic        rst_n;
   logic        desc_valid;
   logic        desc_ready;
   logic [13:0] desc_dst;
   logic [5:0]  desc_len;
   logic [3:0]  desc_vc;
   logic        step;
   logic [3:0]  can_inject;
   logic [21:0] flit_out;
   logic        idle;
   logic [15:0] pkt_count;
   logic [15:0] flit_count;
   logic [15:0] err_count;

   int n_checks = 0;
   int n_fail   = 0;

   flit_injector dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .desc_valid (desc_valid),
      .desc_ready (desc_ready),
      .desc_dst   (desc_dst),
      .desc_len   (desc_len),
      .desc_vc    (desc_vc),
      .step       (step),
      .can_inject (can_inject),
      .flit_out   (flit_out),
      .idle       (idle),
      .pkt_count  (pkt_count),
      .flit_count (flit_count),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [21:0] mk_flit(input logic [3:0] vc, input logic head,
                                           input logic tail, input logic [13:0] dst);
      return {1'b1, vc, 1'b0, head, tail, dst};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_step();
      step = 1'b1;
      tick();
      step = 1'b0;
   endtask

   task automatic push(input logic [13:0] dst, input logic [5:0] len, input logic [3:0] vc);
      desc_valid = 1'b1;
      desc_dst   = dst;
      desc_len   = len;
      desc_vc    = vc;
      tick();
      desc_valid = 1'b0;
   endtask

   task automatic clear_sent();
      can_inject = 4'b0000;
      tick();
      can_inject = 4'b1111;
   endtask

   logic [13:0] t5_dst [5];
   logic [3:0]  t5_vc  [5];

   initial begin
      rst_n      = 1'b0;
      desc_valid = 1'b1;
      desc_dst   = 14'd9;
      desc_len   = 6'd2;
      desc_vc    = 4'd0;
      step       = 1'b0;
      can_inject = 4'b1111;

      // 1: reset held with desc_valid high
      repeat (3) tick();
      check_eq("rst_flit", 32'(flit_out), 32'h0);
      check_eq("rst_ready", 32'(desc_ready), 32'h1);
      check_eq("rst_idle", 32'(idle), 32'h1);
      check_eq("rst_pkt", 32'(pkt_count), 32'h0);
      check_eq("rst_flits", 32'(flit_count), 32'h0);
      check_eq("rst_err", 32'(err_count), 32'h0);
      desc_valid = 1'b0;
      rst_n      = 1'b1;
      tick();
      check_eq("rst_nopush_idle", 32'(idle), 32'h1);

      // 2: three-flit packet on VC1 with can_inject[1] toggled between steps
      push(14'd12, 6'd3, 4'd1);
      tick();
      do_step();
      check_eq("t2_head", 32'(flit_out), 32'h22800C);
      can_inject[1] = 1'b0;
      tick();
      can_inject[1] = 1'b1;
      tick();
      check_eq("t2_hold", 32'(flit_out), 32'h22800C);
      do_step();
      check_eq("t2_body", 32'(flit_out), 32'h22000C);
      can_inject[1] = 1'b0;
      tick();
      can_inject[1] = 1'b1;
      do_step();
      check_eq("t2_tail", 32'(flit_out), 32'h22400C);
      check_eq("t2_pkt", 32'(pkt_count), 32'd1);
      check_eq("t2_flits", 32'(flit_count), 32'd3);

      // 3: single-flit packet, can_inject[0] held high across two steps
      push(14'd5, 6'd1, 4'd0);
      tick();
      do_step();
      check_eq("t3_flit", 32'(flit_out), 32'h20C005);
      do_step();
      check_eq("t3_second_step", 32'(flit_out), 32'h0);
      check_eq("t3_pkt", 32'(pkt_count), 32'd2);
      check_eq("t3_flits", 32'(flit_count), 32'd4);

      // 4: zero-length and out-of-range-VC descriptors are dropped
      push(14'd1, 6'd0, 4'd0);
      push(14'd2, 6'd2, 4'd7);
      tick();
      tick();
      check_eq("t4_err", 32'(err_count), 32'd2);
      do_step();
      check_eq("t4_noflit", 32'(flit_out), 32'h0);
      check_eq("t4_flits", 32'(flit_count), 32'd4);
      clear_sent();
      tick();
      check_eq("t4_idle", 32'(idle), 32'h1);

      // 5: five back-to-back descriptors into a depth-4 FIFO, no steps
      for (int k = 0; k < 5; k++) begin
         t5_dst[k] = 14'(100 + k);
         t5_vc[k]  = 4'(k % 4);
      end
      desc_valid = 1'b1;
      desc_len   = 6'd1;
      for (int k = 0; k < 5; k++) begin
         desc_dst = t5_dst[k];
         desc_vc  = t5_vc[k];
         check_eq($sformatf("t5_ready%0d", k), 32'(desc_ready), 32'h1);
         tick();
      end
      desc_valid = 1'b0;
      check_eq("t5_full", 32'(desc_ready), 32'h0);
      for (int k = 0; k < 5; k++) begin
         clear_sent();
         tick();
         do_step();
         check_eq($sformatf("t5_flit%0d", k), 32'(flit_out),
                  32'(mk_flit(t5_vc[k], 1'b1, 1'b1, t5_dst[k])));
      end
      check_eq("t5_pkt", 32'(pkt_count), 32'd7);
      check_eq("t5_flits", 32'(flit_count), 32'd9);
      check_eq("t5_ready_after", 32'(desc_ready), 32'h1);
      clear_sent();
      tick();
      check_eq("t5_idle", 32'(idle), 32'h1);

      // 6: reset after the head of a four-flit packet
      push(14'd33, 6'd4, 4'd2);
      tick();
      do_step();
      check_eq("t6_head", 32'(flit_out), 32'(mk_flit(4'd2, 1'b1, 1'b0, 14'd33)));
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_flit", 32'(flit_out), 32'h0);
      check_eq("t6_rst_idle", 32'(idle), 32'h1);
      check_eq("t6_rst_ready", 32'(desc_ready), 32'h1);
      check_eq("t6_rst_pkt", 32'(pkt_count), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      push(14'd7, 6'd2, 4'd3);
      tick();
      do_step();
      check_eq("t6_new_head", 32'(flit_out), 32'(mk_flit(4'd3, 1'b1, 1'b0, 14'd7)));
      check_eq("t6_flits", 32'(flit_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
